// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit common-anode seven-segment scan controller.
// Contents: slot-state encoding, display geometry constants, hex->segment decode.
// Segment vectors are {g,f,e,d,c,b,a}, active-low; anode vectors are active-low.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,   // phase 0 of every slot: ghosting guard, nothing lit
        ST_ON    = 2'd1,   // phases 1..bright: selected digit lit
        ST_DARK  = 2'd2    // phases bright+1..7: nothing lit (PWM off time)
    } slot_state_e;

    localparam int         NUM_DIGITS = 4;
    localparam int         NUM_PHASES = 8;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;

    // Standard hex font, active-low, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex.sv
// Combinational hex nibble to seven-segment pattern decoder.
// Ports: nibble_i (4-bit hex digit) -> seg_o (7-bit {g,f,e,d,c,b,a}, active-low).
// Zero latency; no handshake, pure function of the input.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display with
// double-buffered contents and per-slot PWM brightness.
// Ports: clk/rst (sync active-high); load strobe with value/dp_in/dig_en/bright
// into the pending buffer; an/seg/dp active-low pins; frame_tick end-of-frame pulse.
// Latency: all pins registered, one cycle behind the counter/slot state.
// No backpressure: load is always accepted, only the last load in a frame is kept.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int PHASE_LEN = 6250,
    parameter int PHASE_W   = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  dig_en,
    input  logic [2:0]  bright,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam logic [PHASE_W-1:0] CNT_MAX   = PHASE_W'(PHASE_LEN - 1);
    localparam logic [2:0]         PHASE_MAX = 3'(NUM_PHASES - 1);
    localparam logic [1:0]         PTR_MAX   = 2'(NUM_DIGITS - 1);

    // Scan counters
    logic [PHASE_W-1:0] cnt_q, cnt_d;
    logic [2:0]         phase_q, phase_d;
    logic [1:0]         ptr_q, ptr_d;

    // Slot FSM and the brightness latched for the current slot
    slot_state_e state_q, state_d;
    logic [2:0]  slot_bright_q, slot_bright;

    // Active (displayed) and pending (host-written) buffers
    logic [15:0] act_value_q, pend_value_q;
    logic [3:0]  act_dp_q,    pend_dp_q;
    logic [3:0]  act_en_q,    pend_en_q;
    logic [2:0]  act_bright_q, pend_bright_q;

    // Registered pins
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic       tick_q;

    logic       cnt_wrap, phase_wrap, frame_end, slot_start;
    logic [6:0] seg_dec;

    assign cnt_wrap   = (cnt_q == CNT_MAX);
    assign phase_wrap = cnt_wrap && (phase_q == PHASE_MAX);
    assign frame_end  = phase_wrap && (ptr_q == PTR_MAX);
    assign slot_start = (phase_q == 3'd0) && (cnt_q == '0);

    // On the first cycle of a slot the latch has not been loaded yet, so the
    // active buffer is looked at directly; this keeps PHASE_LEN=1 correct too.
    assign slot_bright = slot_start ? act_bright_q : slot_bright_q;

    hex_to_seg7 u_dec (
        .nibble_i (act_value_q[{ptr_q, 2'b00} +: 4]),
        .seg_o    (seg_dec)
    );

    // Counter next-state; phase and ptr wrap naturally at their widths.
    always_comb begin
        cnt_d   = cnt_wrap ? '0 : cnt_q + 1'b1;
        phase_d = cnt_wrap ? phase_q + 3'd1 : phase_q;
        ptr_d   = phase_wrap ? ptr_q + 2'd1 : ptr_q;
    end

    // Slot FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_wrap) begin
                    state_d = (slot_bright != 3'd0) ? ST_ON : ST_DARK;
                end
            end
            ST_ON: begin
                // Slot end wins over the bright==7 case, which ends on phase 7.
                if (phase_wrap) begin
                    state_d = ST_BLANK;
                end else if (cnt_wrap && (phase_q == slot_bright)) begin
                    state_d = ST_DARK;
                end
            end
            ST_DARK: begin
                if (phase_wrap) begin
                    state_d = ST_BLANK;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Pin next-state: blank everything unless the slot is lit.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_q == ST_ON) begin
            if (act_en_q[ptr_q]) begin
                an_d[ptr_q] = 1'b0;
            end
            seg_d = seg_dec;
            dp_d  = ~act_dp_q[ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            phase_q       <= '0;
            ptr_q         <= '0;
            state_q       <= ST_BLANK;
            slot_bright_q <= '0;
            act_value_q   <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
            act_bright_q  <= '0;
            pend_value_q  <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            pend_bright_q <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            tick_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            ptr_q         <= ptr_d;
            state_q       <= state_d;
            slot_bright_q <= slot_bright;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            tick_q        <= frame_end;

            if (load) begin
                pend_value_q  <= value;
                pend_dp_q     <= dp_in;
                pend_en_q     <= dig_en;
                pend_bright_q <= bright;
            end

            // Active only changes at the frame boundary; a load landing on that
            // very cycle bypasses pending so it is shown in the next slot 0.
            if (frame_end) begin
                if (load) begin
                    act_value_q  <= value;
                    act_dp_q     <= dp_in;
                    act_en_q     <= dig_en;
                    act_bright_q <= bright;
                end else begin
                    act_value_q  <= pend_value_q;
                    act_dp_q     <= pend_dp_q;
                    act_en_q     <= pend_en_q;
                    act_bright_q <= pend_bright_q;
                end
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with PHASE_LEN=4 (32-cycle slot, 128-cycle frame).
// Sample index n counts negedges after the frame_tick sample: slot s, phase p, cycle c
// appears at n = 1 + 32*s + 4*p + c.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  dig_en;
    logic [2:0]  bright;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] cap_an   [1:128];
    logic [6:0] cap_seg  [1:128];
    logic       cap_dp   [1:128];
    logic       cap_tick [1:128];

    int trk_bad_seg;
    int trk_low_odd;
    int trk_ticks;

    seg7_scan_ctrl #(.PHASE_LEN(4), .PHASE_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .dig_en     (dig_en),
        .bright     (bright),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] e, input logic [2:0] b);
        value = v; dp_in = d; dig_en = e; bright = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int k;
        k = 0;
        while (k < 300) begin
            @(negedge clk);
            k++;
            if (frame_tick) break;
        end
        if (!frame_tick) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic measure_to_tick(output int cycles, output int lit);
        cycles = 0;
        lit    = 0;
        while (cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (an !== 4'hF) lit++;
            if (frame_tick) break;
        end
    endtask

    task automatic capture_frame();
        for (int n = 1; n <= 128; n++) begin
            @(negedge clk);
            cap_an[n]   = an;
            cap_seg[n]  = seg;
            cap_dp[n]   = dp;
            cap_tick[n] = frame_tick;
        end
    endtask

    function automatic int low_count(input int k);
        int c;
        c = 0;
        for (int n = 1; n <= 128; n++) if (cap_an[n][k] == 1'b0) c++;
        return c;
    endfunction

    function automatic int early_ticks();
        int c;
        c = 0;
        for (int n = 1; n <= 127; n++) if (cap_tick[n]) c++;
        return c;
    endfunction

    // Steps cycles, flagging any A/5 glyph and any low anode on digits 1/3.
    task automatic run_track(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (seg == 7'h08 || seg == 7'h12) trk_bad_seg++;
            if (an[1] == 1'b0 || an[3] == 1'b0) trk_low_odd++;
            if (frame_tick) trk_ticks++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, lit;
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; dig_en = '0; bright = '0;

        // 1. reset and free-running frame timing
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_tick", frame_tick, 1'b0);
        rst = 1'b0;
        measure_to_tick(cyc, lit);
        check("first_tick_delay", cyc, 128);
        check("unloaded_dark", lit, 0);
        measure_to_tick(cyc, lit);
        check("tick_period", cyc, 128);

        // 2. full brightness, all digits, dp on digit 0
        do_load(16'h1234, 4'b0001, 4'hF, 3'd7);
        wait_tick("t2");
        capture_frame();
        check("t2_blank_an", cap_an[4], 4'hF);
        check("t2_blank_seg", cap_seg[4], 7'h7F);
        check("t2_s0_an", cap_an[5], 4'hE);
        check("t2_s0_seg", cap_seg[5], 7'h19);
        check("t2_s0_dp", cap_dp[5], 1'b0);
        check("t2_s0_last", cap_an[32], 4'hE);
        check("t2_s1_blank", cap_an[33], 4'hF);
        check("t2_s1_an", cap_an[37], 4'hD);
        check("t2_s1_seg", cap_seg[37], 7'h30);
        check("t2_s1_dp", cap_dp[37], 1'b1);
        check("t2_s2_an", cap_an[69], 4'hB);
        check("t2_s2_seg", cap_seg[69], 7'h24);
        check("t2_s3_an", cap_an[101], 4'h7);
        check("t2_s3_seg", cap_seg[101], 7'h79);
        for (int k = 0; k < 4; k++) check($sformatf("t2_low%0d", k), low_count(k), 28);
        check("t2_tick_end", cap_tick[128], 1'b1);
        check("t2_tick_early", early_ticks(), 0);

        // 3. bright=2: phases 1-2 only
        do_load(16'h1234, 4'b0000, 4'hF, 3'd2);
        wait_tick("t3");
        capture_frame();
        for (int k = 0; k < 4; k++) check($sformatf("t3_low%0d", k), low_count(k), 8);
        check("t3_on_last", cap_an[12], 4'hE);
        check("t3_dark_an", cap_an[13], 4'hF);
        check("t3_dark_seg", cap_seg[13], 7'h7F);
        check("t3_dark_dp", cap_dp[13], 1'b1);

        // 4. digits 0 and 2 only
        do_load(16'h1234, 4'b0000, 4'b0101, 3'd7);
        wait_tick("t4");
        capture_frame();
        check("t4_low0", low_count(0), 28);
        check("t4_low1", low_count(1), 0);
        check("t4_low2", low_count(2), 28);
        check("t4_low3", low_count(3), 0);
        check("t4_tick_end", cap_tick[128], 1'b1);
        check("t4_tick_early", early_ticks(), 0);

        // 5. two mid-frame loads: no effect until frame end, last one wins
        trk_bad_seg = 0; trk_low_odd = 0; trk_ticks = 0;
        run_track(20);
        do_load(16'hAAAA, 4'b0000, 4'hF, 3'd7);
        run_track(20);
        do_load(16'h5555, 4'b0000, 4'hF, 3'd7);
        run_track(86);
        check("t5_no_tear_seg", trk_bad_seg, 0);
        check("t5_no_tear_en", trk_low_odd, 0);
        check("t5_one_tick", trk_ticks, 1);
        check("t5_tick_now", frame_tick, 1'b1);
        capture_frame();
        check("t5_s0_seg", cap_seg[5], 7'h12);
        check("t5_s3_seg", cap_seg[101], 7'h12);
        check("t5_low1", low_count(1), 28);

        // 5b. load on the frame-end cycle bypasses into the next slot 0
        run_track(127);
        value = 16'h0F08; dp_in = 4'b0000; dig_en = 4'hF; bright = 3'd7; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("t5b_tick", frame_tick, 1'b1);
        capture_frame();
        check("t5b_s0_seg", cap_seg[5], 7'h00);
        check("t5b_s1_seg", cap_seg[37], 7'h40);
        check("t5b_s2_seg", cap_seg[69], 7'h0E);
        check("t5b_s3_seg", cap_seg[101], 7'h40);
        capture_frame();
        check("t5b_kept_seg", cap_seg[5], 7'h00);

        // 6. bright=0: dark for three frames, ticks continue
        do_load(16'h1234, 4'b0000, 4'hF, 3'd0);
        wait_tick("t6");
        for (int f = 0; f < 3; f++) begin
            capture_frame();
            check($sformatf("t6_dark_f%0d", f),
                  low_count(0) + low_count(1) + low_count(2) + low_count(3), 0);
            check($sformatf("t6_tick_f%0d", f), cap_tick[128], 1'b1);
        end

        // 1b. reset mid-slot while lit
        do_load(16'h1234, 4'b0000, 4'hF, 3'd7);
        wait_tick("t7");
        repeat (9) @(negedge clk);
        check("t7_lit_before", an, 4'hE);
        rst = 1'b1;
        @(negedge clk);
        check("t7_rst_an", an, 4'hF);
        check("t7_rst_seg", seg, 7'h7F);
        check("t7_rst_dp", dp, 1'b1);
        check("t7_rst_tick", frame_tick, 1'b0);
        rst = 1'b0;
        measure_to_tick(cyc, lit);
        check("t7_restart", cyc, 128);
        check("t7_cleared", lit, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
